// File: rtl/debouncer_multi.sv
// debouncer_multi: per-channel two-flop synchroniser plus a debounce/hold FSM
// producing a debounced level and single-cycle press, release, long-press and
// auto-repeat events. Channels share only clk and rst.
module debouncer_multi #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned DELAY    = 15,
    parameter int unsigned HOLD     = 1000,
    parameter int unsigned REPEAT   = 250
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] PB,
    output logic [CHANNELS-1:0] PB_pressed_status,
    output logic [CHANNELS-1:0] PB_pressed_pulse,
    output logic [CHANNELS-1:0] PB_released_pulse,
    output logic [CHANNELS-1:0] PB_long_pulse,
    output logic [CHANNELS-1:0] PB_repeat_pulse
);

    localparam int unsigned DW   = $clog2(DELAY + 1);
    localparam int unsigned HMAX = (HOLD > REPEAT) ? HOLD : REPEAT;
    localparam int unsigned HW   = $clog2(HMAX + 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    logic [CHANNELS-1:0] sync_aux;
    logic [CHANNELS-1:0] s;

    // Two-flop synchroniser for the raw asynchronous button inputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_aux <= '0;
            s        <= '0;
        end else begin
            sync_aux <= PB;
            s        <= sync_aux;
        end
    end

    for (genvar g = 0; g < int'(CHANNELS); g++) begin : g_ch
        state_t          state;
        logic [DW-1:0]   dcnt;
        logic [HW-1:0]   hcnt;
        logic [HW-1:0]   rcnt;
        logic [HW-1:0]   hcnt_inc;
        logic            long_done;
        logic            pressed_status;
        logic            pressed_pulse;
        logic            released_pulse;
        logic            long_pulse;
        logic            repeat_pulse;

        // Saturating increment of the hold counter
        assign hcnt_inc = (hcnt == {HW{1'b1}}) ? hcnt : hcnt + HW'(1);

        // Debounce / hold state machine with registered level and event outputs
        always_ff @(posedge clk) begin
            if (!rst) begin
                state          <= IDLE;
                dcnt           <= '0;
                hcnt           <= '0;
                rcnt           <= '0;
                long_done      <= 1'b0;
                pressed_status <= 1'b0;
                pressed_pulse  <= 1'b0;
                released_pulse <= 1'b0;
                long_pulse     <= 1'b0;
                repeat_pulse   <= 1'b0;
            end else begin
                pressed_pulse  <= 1'b0;
                released_pulse <= 1'b0;
                long_pulse     <= 1'b0;
                repeat_pulse   <= 1'b0;
                case (state)
                    IDLE: begin
                        if (s[g]) begin
                            state <= PRESS_WAIT;
                            dcnt  <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!s[g]) begin
                            state <= IDLE;
                            dcnt  <= '0;
                            hcnt  <= '0;
                            rcnt  <= '0;
                        end else if (dcnt == DW'(DELAY - 1)) begin
                            state          <= HELD;
                            dcnt           <= '0;
                            hcnt           <= '0;
                            rcnt           <= '0;
                            long_done      <= 1'b0;
                            pressed_pulse  <= 1'b1;
                            pressed_status <= 1'b1;
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                    HELD: begin
                        if (!s[g]) begin
                            state <= RELEASE_WAIT;
                            dcnt  <= '0;
                        end else begin
                            hcnt <= hcnt_inc;
                            if (!long_done && (hcnt_inc >= HW'(HOLD - 1))) begin
                                long_pulse <= 1'b1;
                                long_done  <= 1'b1;
                                rcnt       <= '0;
                            end else if (long_done && (REPEAT != 0)) begin
                                if (rcnt == HW'(REPEAT - 1)) begin
                                    repeat_pulse <= 1'b1;
                                    rcnt         <= '0;
                                end else begin
                                    rcnt <= rcnt + HW'(1);
                                end
                            end
                        end
                    end
                    RELEASE_WAIT: begin
                        // A return to 1 is a dropout glitch; hold progress is kept
                        if (s[g]) begin
                            state <= HELD;
                            dcnt  <= '0;
                        end else if (dcnt == DW'(DELAY - 1)) begin
                            state          <= IDLE;
                            dcnt           <= '0;
                            hcnt           <= '0;
                            rcnt           <= '0;
                            long_done      <= 1'b0;
                            released_pulse <= 1'b1;
                            pressed_status <= 1'b0;
                        end else begin
                            dcnt <= dcnt + DW'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                        dcnt  <= '0;
                    end
                endcase
            end
        end

        assign PB_pressed_status[g] = pressed_status;
        assign PB_pressed_pulse[g]  = pressed_pulse;
        assign PB_released_pulse[g] = released_pulse;
        assign PB_long_pulse[g]     = long_pulse;
        assign PB_repeat_pulse[g]   = repeat_pulse;
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Directed bench for debouncer_multi with DELAY=4, HOLD=20, REPEAT=5.
// Edge e is counted from the first rising edge after PB is set up for a scenario.
module tb_debouncer_multi;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] pb  = 4'h0;
    logic [3:0] pressed_status;
    logic [3:0] pressed_pulse;
    logic [3:0] released_pulse;
    logic [3:0] long_pulse;
    logic [3:0] repeat_pulse;

    int n_pass   = 0;
    int n_checks = 0;

    debouncer_multi #(
        .CHANNELS(4),
        .DELAY   (4),
        .HOLD    (20),
        .REPEAT  (5)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .PB               (pb),
        .PB_pressed_status(pressed_status),
        .PB_pressed_pulse (pressed_pulse),
        .PB_released_pulse(released_pulse),
        .PB_long_pulse    (long_pulse),
        .PB_repeat_pulse  (repeat_pulse)
    );

    always #5 clk = ~clk;

    // Count one comparison and report it if it differs
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Advance one edge and check all five outputs against expectations
    task automatic cycle(input string tag, input int e,
                         input logic [3:0] pr, input logic [3:0] rl,
                         input logic [3:0] lg, input logic [3:0] rp,
                         input logic [3:0] st);
        @(posedge clk);
        #1;
        check($sformatf("%s_pressed_e%0d", tag, e),  32'(pressed_pulse),  32'(pr));
        check($sformatf("%s_released_e%0d", tag, e), 32'(released_pulse), 32'(rl));
        check($sformatf("%s_long_e%0d", tag, e),     32'(long_pulse),     32'(lg));
        check($sformatf("%s_repeat_e%0d", tag, e),   32'(repeat_pulse),   32'(rp));
        check($sformatf("%s_status_e%0d", tag, e),   32'(pressed_status), 32'(st));
    endtask

    int bounce [5] = '{1, 0, 1, 1, 0};

    initial begin
        // Reset held with all buttons high: everything stays 0
        rst = 1'b0;
        pb  = 4'hF;
        for (int i = 0; i < 3; i++) cycle("rst", i, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        // Buttons held through reset release need the full debounce
        rst = 1'b1;
        for (int e = 0; e <= 7; e++)
            cycle("post_rst", e, (e == 6) ? 4'hF : 4'h0, 4'h0, 4'h0, 4'h0,
                  (e >= 6) ? 4'hF : 4'h0);
        pb = 4'h0;
        for (int e = 8; e <= 16; e++)
            cycle("post_rst_rel", e, 4'h0, (e == 14) ? 4'hF : 4'h0, 4'h0, 4'h0,
                  (e < 14) ? 4'hF : 4'h0);

        // Clean press of channel 0 for 10 cycles
        for (int e = 0; e <= 22; e++) begin
            pb = (e < 10) ? 4'h1 : 4'h0;
            cycle("clean", e, (e == 6) ? 4'h1 : 4'h0, (e == 16) ? 4'h1 : 4'h0,
                  4'h0, 4'h0, (e >= 6 && e < 16) ? 4'h1 : 4'h0);
        end

        // Bouncing channel 1 never gets accepted
        for (int e = 0; e <= 10; e++) begin
            pb = (e < 5 && bounce[e] != 0) ? 4'h2 : 4'h0;
            cycle("bounce", e, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        end

        // Channel 1 press with a 2-cycle dropout while held
        for (int e = 0; e <= 30; e++) begin
            pb = (e < 20 && e != 12 && e != 13) ? 4'h2 : 4'h0;
            cycle("dropout", e, (e == 6) ? 4'h2 : 4'h0, (e == 26) ? 4'h2 : 4'h0,
                  4'h0, 4'h0, (e >= 6 && e < 26) ? 4'h2 : 4'h0);
        end

        // Channel 2 long press with auto-repeat
        for (int e = 0; e <= 56; e++) begin
            pb = (e < 46) ? 4'h4 : 4'h0;
            cycle("long", e, (e == 6) ? 4'h4 : 4'h0, (e == 52) ? 4'h4 : 4'h0,
                  (e == 25) ? 4'h4 : 4'h0,
                  (e == 30 || e == 35 || e == 40 || e == 45) ? 4'h4 : 4'h0,
                  (e >= 6 && e < 52) ? 4'h4 : 4'h0);
        end

        // All channels together, channel 3 released early
        for (int e = 0; e <= 40; e++) begin
            logic [3:0] rl;
            logic [3:0] st;
            pb = (e < 12) ? 4'hF : ((e < 30) ? 4'h7 : 4'h0);
            rl = (e == 18) ? 4'h8 : ((e == 36) ? 4'h7 : 4'h0);
            st = (e < 6) ? 4'h0 : ((e < 18) ? 4'hF : ((e < 36) ? 4'h7 : 4'h0));
            cycle("multi", e, (e == 6) ? 4'hF : 4'h0, rl, (e == 25) ? 4'h7 : 4'h0,
                  (e == 30) ? 4'h7 : 4'h0, st);
        end

        // Reset while channel 0 is held: status clears, no release event
        for (int e = 0; e <= 9; e++) begin
            pb = 4'h1;
            cycle("mid_hold", e, (e == 6) ? 4'h1 : 4'h0, 4'h0, 4'h0, 4'h0,
                  (e >= 6) ? 4'h1 : 4'h0);
        end
        rst = 1'b0;
        cycle("mid_rst", 10, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        cycle("mid_rst", 11, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);
        rst = 1'b1;
        pb  = 4'h0;
        for (int e = 12; e <= 20; e++) cycle("after_rst", e, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
